// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bus between the EX-stage control unit and the
// multi-cycle multiply/divide sequencer that owns HI/LO.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             stall;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  stall, busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output stall, busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Fixed-latency (WIDTH+2 cycle) MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Iterates on magnitudes, then sign-corrects once in FIX.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    muldiv_sequencer_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [5:0] LAST   = 6'(WIDTH - 1);

    logic [1:0]       state;
    logic [5:0]       cnt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] acc_hi, acc_lo, mag_b, a_raw;
    logic             neg_q, neg_r, bz;

    logic             accept;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] q_fix, r_fix;
    logic             signed_op;

    assign accept    = bus.start & (state == S_IDLE | state == S_DONE);
    assign bus.stall = accept | bus.busy;

    // op[0]==0 selects the signed variants (MULT, DIV)
    assign a_mag = (~bus.op[0] & bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag = (~bus.op[0] & bus.b[WIDTH-1]) ? -bus.b : bus.b;

    assign mul_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? mag_b : '0)};
    assign div_sh  = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge  = div_sh >= {1'b0, mag_b};
    // when div_ge holds the true difference is < mag_b, so the low bits suffice
    assign div_sub = div_sh[WIDTH-1:0] - mag_b;

    assign signed_op = ~op_q[0];
    assign prod      = {acc_hi, acc_lo};
    assign prod_fix  = (signed_op & neg_q) ? -prod : prod;
    assign q_fix     = (signed_op & neg_q) ? -acc_lo : acc_lo;
    assign r_fix     = (signed_op & neg_r) ? -acc_hi : acc_hi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            cnt             <= '0;
            op_q            <= '0;
            acc_hi          <= '0;
            acc_lo          <= '0;
            mag_b           <= '0;
            a_raw           <= '0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            bz              <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
            bus.hi          <= '0;
            bus.lo          <= '0;
        end else begin
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state    <= S_RUN;
                        bus.busy <= 1'b1;
                        cnt      <= '0;
                        op_q     <= bus.op;
                        acc_hi   <= '0;
                        acc_lo   <= a_mag;
                        mag_b    <= b_mag;
                        a_raw    <= bus.a;
                        neg_q    <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        neg_r    <= bus.a[WIDTH-1];
                        bz       <= (bus.b == '0);
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (op_q[1]) begin
                        acc_hi <= div_ge ? div_sub : div_sh[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end else begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                    end
                    cnt <= cnt + 6'd1;
                    if (cnt == LAST)
                        state <= S_FIX;
                end
                S_FIX: begin
                    if (!op_q[1]) begin
                        bus.hi <= prod_fix[2*WIDTH-1:WIDTH];
                        bus.lo <= prod_fix[WIDTH-1:0];
                    end else if (bz) begin
                        bus.hi          <= a_raw;
                        bus.lo          <= '1;
                        bus.div_by_zero <= 1'b1;
                    end else begin
                        bus.hi <= r_fix;
                        bus.lo <= q_fix;
                    end
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed test-plan cases plus
// randomized ops against a plain-arithmetic HI/LO model.
module tb_muldiv_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(32)) bus();
    muldiv_sequencer #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] cur_hi = '0, cur_lo = '0;
    logic [31:0] exp_hi, exp_lo;
    logic        exp_dbz;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {dbz, hi, lo} from integer arithmetic
    function automatic logic [64:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy, p, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        case (o)
            2'd0: begin p = sx * sy; return {1'b0, p}; end
            2'd1: begin p = ux * uy; return {1'b0, p}; end
            default: begin
                if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
                q = (o == 2'd2) ? sx / sy : ux / uy;
                r = (o == 2'd2) ? sx % sy : ux % uy;
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Called right after a negedge; returns at the negedge after the accepting edge.
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [64:0] r;
        r = ref_op(o, x, y);
        exp_dbz = r[64];
        exp_hi  = r[63:32];
        exp_lo  = r[31:0];
        bus.start = 1'b1;
        bus.op = o;
        bus.a = x;
        bus.b = y;
        #1 chk("stall_on_start", 64'(bus.stall), 64'd1);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op = 2'($urandom);
        bus.a = $urandom;
        bus.b = $urandom;
    endtask

    task automatic wait_result(input string tag, input int inject_k);
        int k;
        int stall_n = 0, hold_bad = 0;
        bit seen = 0;
        for (k = 1; k <= 40; k++) begin
            if (bus.done) begin seen = 1; break; end
            if (bus.stall) stall_n++;
            if (bus.hi !== cur_hi || bus.lo !== cur_lo || bus.div_by_zero !== 1'b0) hold_bad++;
            if (k == inject_k) begin
                bus.start = 1'b1;
                bus.op = 2'($urandom);
                bus.a = $urandom;
                bus.b = $urandom;
            end
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk({tag, "_latency"}, 64'(k), 64'd34);
        chk({tag, "_stall_cycles"}, 64'(stall_n), 64'd33);
        chk({tag, "_hold"}, 64'(hold_bad), 64'd0);
        if (seen) begin
            chk({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
            chk({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
            chk({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(exp_dbz));
            chk({tag, "_stall_done"}, 64'(bus.stall), 64'd0);
            chk({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
        end
        cur_hi = exp_hi;
        cur_lo = exp_lo;
    endtask

    task automatic post_idle(input string tag);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        chk({tag, "_dbz_pulse"}, 64'(bus.div_by_zero), 64'd0);
        chk({tag, "_busy_idle"}, 64'(bus.busy), 64'd0);
        chk({tag, "_hi_idle"}, 64'(bus.hi), 64'(cur_hi));
        chk({tag, "_lo_idle"}, 64'(bus.lo), 64'(cur_lo));
    endtask

    logic [1:0]  d_op [8] = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3, 2'd3};
    logic [31:0] d_a  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9,
                             32'd100, 32'h8000_0000, 32'h0000_1234, 32'd9};
    logic [31:0] d_b  [8] = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd2,
                             32'd7, 32'hFFFF_FFFF, 32'd0, 32'd3};
    logic [31:0] d_hi [8] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF,
                             32'd2, 32'd0, 32'h0000_1234, 32'd0};
    logic [31:0] d_lo [8] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'h0000_0000, 32'hFFFF_FFFD,
                             32'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'd3};

    initial begin
        int late_done;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.op = 2'd0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(negedge clk);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
        chk("rst_stall", 64'(bus.stall), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            launch(d_op[i], d_a[i], d_b[i]);
            wait_result($sformatf("dir%0d", i), 0);
            chk($sformatf("dir%0d_hi_const", i), 64'(bus.hi), 64'(d_hi[i]));
            chk($sformatf("dir%0d_lo_const", i), 64'(bus.lo), 64'(d_lo[i]));
            post_idle($sformatf("dir%0d", i));
        end

        // start pulsed during RUN must be ignored
        launch(2'd1, 32'd6, 32'd7);
        wait_result("inject", 5);
        post_idle("inject");

        // back-to-back: second start in the DONE cycle
        launch(2'd3, 32'd1000, 32'd3);
        wait_result("chain_a", 0);
        launch(2'd0, 32'hFFFF_FF00, 32'd12345);
        wait_result("chain_b", 0);
        post_idle("chain_b");

        // asynchronous reset mid-RUN
        launch(2'd1, $urandom, $urandom);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_hi", 64'(bus.hi), 64'd0);
        chk("arst_lo", 64'(bus.lo), 64'd0);
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_done", 64'(bus.done), 64'd0);
        chk("arst_dbz", 64'(bus.div_by_zero), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cur_hi = '0;
        cur_lo = '0;
        late_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.hi != 32'd0 || bus.lo != 32'd0) late_done++;
        end
        chk("arst_quiet", 64'(late_done), 64'd0);
        launch(2'd1, 32'd6, 32'd7);
        wait_result("after_rst", 0);
        chk("after_rst_lo_const", 64'(bus.lo), 64'd42);
        chk("after_rst_hi_const", 64'(bus.hi), 64'd0);
        post_idle("after_rst");

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            launch(ro, ra, rb);
            wait_result($sformatf("rnd%0d_op%0d", i, ro), 0);
            if ($urandom_range(0, 1) == 1) post_idle($sformatf("rnd%0d", i));
        end
        post_idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle multiply/divide sequencer that owns the CPU's HI/LO result registers. The EX-stage control unit issues MULT/MULTU/DIV/DIVU on a start strobe. The sequencer freezes fetch/execute through a stall output while it iterates. It then publishes HI/LO with a one-cycle done pulse that the writeback path samples for MFHI/MFLO. This replaces the single-cycle hi/lo path of the ALU, which cannot close timing for 32-bit divide.

## Interface
- WIDTH, 32, operand and result width; the iteration count equals WIDTH.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  issue strobe from control unit, sampled on rising edge
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- a  in  WIDTH  rs operand (multiplicand / dividend), sampled with accepted start
- b  in  WIDTH  rt operand (multiplier / divisor), sampled with accepted start
- stall  out  1  hold PC and instruction_EX; combinational
- busy  out  1  registered; high in RUN and FIX
- done  out  1  registered one-cycle pulse; HI/LO updated this cycle
- div_by_zero  out  1  registered; pulses with done when a divide had b==0
- hi  out  WIDTH  HI register (product high half / remainder)
- lo  out  WIDTH  LO register (product low half / quotient)

## Operation
- FSM states: IDLE, RUN, FIX, DONE.
  - IDLE: start=1 accepts the op and goes to RUN. It latches op, |a| and |b| (magnitudes only for the signed ops), the result signs, and the b==0 flag, and clears the iteration counter.
  - RUN: performs one iteration per cycle and increments a 6-bit counter. After iteration WIDTH-1 it goes to FIX.
  - FIX: applies sign correction, writes hi/lo and the div_by_zero flag, then goes to DONE.
  - DONE: done=1 for one cycle. start=1 here is accepted exactly as in IDLE (goes to RUN); otherwise the FSM goes to IDLE.
- Multiply: unsigned shift-add over a 2×WIDTH accumulator.
  - Signed: the product is negated (two's complement, 2×WIDTH) when sign(a)≠sign(b).
  - Result: hi = product[2W-1:W], lo = product[W-1:0].
- Divide: restoring shift-subtract on magnitudes.
  - Signed: the quotient is negated when sign(a)≠sign(b); the remainder takes the sign of a.
  - Result: lo = quotient, hi = remainder.
  - -2^31 / -1 gives lo=0x80000000, hi=0 (natural wrap, no flag).
- Divide by zero: the full latency still runs. FIX forces lo=all-ones and hi=a as originally sampled (signed, not magnitude), and div_by_zero=1 for the done cycle.
- Operand and result ownership:
  - hi/lo change only in FIX (and on reset). They hold the last result through IDLE, RUN and any later op until that op's FIX.
  - start while busy=1 is ignored: no queueing, no error.
  - a, b and op are don't-care except in the cycle start is accepted.
- Reset (asynchronous, any state including mid-RUN):
  - State goes to IDLE; the counter and internal accumulators clear.
  - hi=0, lo=0, busy=0, done=0, div_by_zero=0.
  - stall follows the combinational rule below.
  - An in-flight op is discarded; no done is produced after reset deasserts.

## Timing
- Rising edge E0 accepts start.
- RUN occupies the cycles after E0 through E32 (32 iterations).
- FIX is the cycle after E32.
- Edge E33 writes hi/lo and sets done.
- done and the new hi/lo are visible in the cycle after E33: fixed latency of 34 cycles from start to result, independent of op and operands.
- stall = (start & (state==IDLE | state==DONE)) | busy.
  - High in the start cycle and every cycle through FIX.
  - Low in the DONE cycle so the stalled instruction advances while hi/lo are already valid.
- busy: high from after E0 through the FIX cycle; low in DONE.
- Back-to-back issue: start in the DONE cycle launches the next op with no IDLE bubble. The previous result stays on hi/lo until the new op's FIX.
- No combinational path from a, b or op to any output; only start→stall is combinational.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF: done exactly 34 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; stall high for 33 cycles, low on the done cycle.
- MULT -3 (0xFFFFFFFD) × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- DIV -7 ÷ 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 ÷ 7 → lo=14, hi=2. DIV 0x80000000 ÷ 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 0x1234 ÷ 0 → lo=0xFFFFFFFF, hi=0x00001234, div_by_zero=1 for exactly the done cycle; a following DIVU 9÷3 gives div_by_zero=0.
- Start pulsed at RUN iteration 5 with other operands is ignored: the result matches the first op. Start held in the DONE cycle launches the second op; its done follows 34 cycles later and hi/lo keep the first result until then.
- Assert rst during RUN iteration 10: hi, lo, busy, done and div_by_zero are 0 immediately; no done pulse within 40 cycles after release; a fresh MULTU 6×7 then yields lo=42, hi=0.
